// File: rtl/fsm_xy_encoder_if.sv
// Word handshake between a data source and fsm_xy_encoder.
// The source drives din/din_valid; the encoder returns din_ready.
interface fsm_xy_encoder_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/fsm_xy_encoder.sv
// Serialises words MSB first into x/y move pulses that make the downstream four-state FSM's z reproduce each bit.
// Optional z_fb checker with sticky err is built when FSM_ENC_CHECK_EN is defined.
module fsm_xy_encoder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 0
) (
    input  logic              clk,
    input  logic              rst,
    fsm_xy_encoder_if.slave   in_if,
    output logic              x,
    output logic              y,
    output logic              busy,
    input  logic              z_fb
`ifdef FSM_ENC_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int unsigned CW       = $clog2(WIDTH + 1);
    localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [3:0] S0 = 4'b0001;
    localparam logic [3:0] S1 = 4'b0010;
    localparam logic [3:0] S2 = 4'b0100;
    localparam logic [3:0] S3 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAPW
    } state_t;

    state_t           state_q, state_d;
    logic             x_q, x_d;
    logic             y_q, y_d;
    logic             busy_q, busy_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             do_send;
    logic             bit_val;

    // Returns {x, y, next shadow}; an illegal shadow encodes like S0 and recovers to S0.
    function automatic logic [5:0] enc(input logic [3:0] s, input logic b);
        logic [5:0] r;
        case (s)
            S0:      r = b ? {2'b01, S3} : {2'b10, S2};
            S1:      r = b ? {2'b10, S2} : {2'b01, S3};
            S2:      r = b ? {2'b01, S3} : {2'b10, S1};
            S3:      r = b ? {2'b10, S1} : {2'b01, S2};
            default: r = b ? {2'b01, S0} : {2'b10, S0};
        endcase
        return r;
    endfunction

    assign in_if.din_ready = (state_q == IDLE) && !rst;

    // Controller next state; the move for a bit is registered in the same edge that enters SEND.
    always_comb begin
        state_d  = state_q;
        x_d      = 1'b0;
        y_d      = 1'b0;
        busy_d   = 1'b0;
        shadow_d = shadow_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        do_send  = 1'b0;
        bit_val  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_if.din_valid) begin
                    do_send = 1'b1;
                    bit_val = in_if.din[WIDTH-1];
                    shift_d = in_if.din << 1;
                    cnt_d   = CW'(1);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = IDLE;
                end else if (GAP == 0) begin
                    do_send = 1'b1;
                    bit_val = shift_q[WIDTH-1];
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    state_d = GAPW;
                    gap_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            GAPW: begin
                busy_d = 1'b1;
                if (gap_q == GW'(GAP_LAST)) begin
                    do_send = 1'b1;
                    bit_val = shift_q[WIDTH-1];
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = SEND;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_send) begin
            {x_d, y_d, shadow_d} = enc(shadow_q, bit_val);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= 1'b0;
            y_q      <= 1'b0;
            busy_q   <= 1'b0;
            shadow_q <= S0;
            shift_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            shadow_q <= shadow_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign busy = busy_q;

`ifdef FSM_ENC_CHECK_EN
    logic exp1_q, chk1_q, exp2_q, chk2_q, err_q;

    // Expected bit rides with its move, then waits one more cycle for the downstream z.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp1_q <= 1'b0;
            chk1_q <= 1'b0;
            exp2_q <= 1'b0;
            chk2_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            exp1_q <= bit_val;
            chk1_q <= do_send;
            exp2_q <= exp1_q;
            chk2_q <= chk1_q;
            if (chk2_q && (z_fb != exp2_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_z_fb;
    assign unused_z_fb = z_fb;
`endif

endmodule

// File: tb/tb_fsm_xy_encoder.sv
// Directed bench for fsm_xy_encoder: scoreboard of expected moves derived from a downstream FSM model.
module tb_fsm_xy_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    bit         sel;
    logic       force_z;

    logic x0, y0, b0, x1, y1, b1;
    logic zfb0;
    logic err0, err1;

    int errors = 0;
    int checks = 0;

    logic [1:0] q_mv[$];
    logic       q_bit[$];
    int         sh[2];

    always #5 clk = ~clk;

    fsm_xy_encoder_if #(.WIDTH(8)) if0 ();
    fsm_xy_encoder_if #(.WIDTH(8)) if1 ();

    assign if0.din       = din;
    assign if0.din_valid = din_valid && !sel;
    assign if1.din       = din;
    assign if1.din_valid = din_valid && sel;

    fsm_xy_encoder #(.WIDTH(8), .GAP(0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .in_if (if0.slave),
        .x     (x0),
        .y     (y0),
        .busy  (b0),
        .z_fb  (zfb0)
`ifdef FSM_ENC_CHECK_EN
        ,
        .err   (err0)
`endif
    );

    fsm_xy_encoder #(.WIDTH(8), .GAP(2)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .in_if (if1.slave),
        .x     (x1),
        .y     (y1),
        .busy  (b1),
        .z_fb  (1'b0)
`ifdef FSM_ENC_CHECK_EN
        ,
        .err   (err1)
`endif
    );

`ifndef FSM_ENC_CHECK_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    wire [1:0] obs_xy    = sel ? {x1, y1} : {x0, y0};
    wire       obs_busy  = sel ? b1 : b0;
    wire       obs_ready = sel ? if1.din_ready : if0.din_ready;

    // Downstream FSM: move A (xy=10) and move B (xy=01), state index 0..3.
    function automatic int ds_next(input int s, input logic a);
        if (a) return (s < 2) ? 2 : 1;
        return (s == 3) ? 2 : 3;
    endfunction

    function automatic logic ds_z(input int s, input logic a);
        logic odd;
        odd = (s == 1) || (s == 3);
        return a ? odd : !odd;
    endfunction

    int   ds_st;
    logic ds_zq;
    always @(posedge clk) begin
        if (rst) begin
            ds_st <= 0;
            ds_zq <= 1'b0;
        end else if (x0 && !y0) begin
            ds_zq <= ds_z(ds_st, 1'b1);
            ds_st <= ds_next(ds_st, 1'b1);
        end else if (!x0 && y0) begin
            ds_zq <= ds_z(ds_st, 1'b0);
            ds_st <= ds_next(ds_st, 1'b0);
        end
    end
    assign zfb0 = force_z ? 1'b0 : ds_zq;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Picks, for each bit, the move whose downstream z equals the bit.
    task automatic load(input logic [7:0] d);
        for (int k = 0; k < 8; k++) begin
            logic b;
            logic a;
            b = d[7-k];
            a = (ds_z(sh[sel], 1'b1) == b);
            q_mv.push_back(a ? 2'b10 : 2'b01);
            q_bit.push_back(b);
            sh[sel] = ds_next(sh[sel], a);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit keep, input logic [7:0] nd);
        int g;
        int last;
        g    = sel ? 2 : 0;
        last = 7 * (g + 1) + 1;
        din       = d;
        din_valid = 1'b1;
        load(d);
        tick();
        if (keep) din = nd;
        else din_valid = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if ((c - 1) % (g + 1) == 0) chk("xy_bit", 8'(obs_xy), 8'(q_mv.pop_front()));
            else chk("xy_gap", 8'(obs_xy), 8'h00);
            chk("busy_word", 8'(obs_busy), 8'h01);
            if (!sel && c >= 2) chk("z_down", 8'(ds_zq), 8'(q_bit.pop_front()));
            if (c < last) tick();
        end
        tick();
        chk("xy_end", 8'(obs_xy), 8'h00);
        chk("busy_end", 8'(obs_busy), 8'h00);
        chk("ready_end", 8'(obs_ready), 8'h01);
        if (!sel) chk("z_last", 8'(ds_zq), 8'(q_bit.pop_front()));
        if (sel) q_bit.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_x", 8'(x0), 8'h00);
        chk("rst_y", 8'(y0), 8'h00);
        chk("rst_busy", 8'(b0), 8'h00);
        chk("rst_ready", 8'(if0.din_ready), 8'h00);
        rst = 1'b0;
        sh[0] = 0;
        sh[1] = 0;
        q_mv.delete();
        q_bit.delete();
        #1;
        chk("ready_after_rst", 8'(if0.din_ready), 8'h01);
    endtask

    initial begin
        sel       = 1'b0;
        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        force_z   = 1'b0;

        do_reset();
        send(8'hA5, 1'b0, 8'h00);

        do_reset();
        send(8'h00, 1'b0, 8'h00);

        do_reset();
        send(8'hA5, 1'b1, 8'h5A);
        chk("b2b_ready_valid", 8'(if0.din_ready && din_valid), 8'h01);
        send(8'h5A, 1'b0, 8'h00);

        // Abort a word at T+4 and confirm a clean restart from S0.
        do_reset();
        din       = 8'hA5;
        din_valid = 1'b1;
        load(8'hA5);
        tick();
        din_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("xy_pre_abort", 8'({x0, y0}), 8'(q_mv.pop_front()));
            if (c < 4) tick();
        end
        rst = 1'b1;
        tick();
        chk("abort_xy", 8'({x0, y0}), 8'h00);
        chk("abort_busy", 8'(b0), 8'h00);
        chk("abort_ready", 8'(if0.din_ready), 8'h00);
        rst = 1'b0;
        sh[0] = 0;
        q_mv.delete();
        q_bit.delete();
        tick();
        send(8'hA5, 1'b0, 8'h00);
        chk("err_clean", 8'(err0), 8'h00);

        sel = 1'b1;
        send(8'hA5, 1'b0, 8'h00);
        sel = 1'b0;

`ifdef FSM_ENC_CHECK_EN
        do_reset();
        chk("err_reset", 8'(err0), 8'h00);
        force_z   = 1'b1;
        din       = 8'hFF;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("err_t1", 8'(err0), 8'h00);
        tick();
        chk("err_t2", 8'(err0), 8'h00);
        tick();
        chk("err_t3", 8'(err0), 8'h01);
        for (int i = 0; i < 8; i++) tick();
        chk("err_sticky", 8'(err0), 8'h01);
        force_z = 1'b0;
        rst = 1'b1;
        tick();
        chk("err_cleared", 8'(err0), 8'h00);
        rst = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
